// File: rtl/afifo_rx_ctrl_v2_if.sv
// Read-side bundle of the asynchronous FIFO: reader handshake, storage port and pointer exchange.
interface afifo_rx_ctrl_v2_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic                  REN;
   logic                  UF_CLR;
   logic [ADDR_WIDTH:0]   W_PTR_GRAY;
   logic [DATA_WIDTH-1:0] R_DATA_Tx;
   logic [DATA_WIDTH-1:0] R_DATA;
   logic                  R_VALID;
   logic                  R_EMPTY;
   logic                  R_AEMPTY;
   logic [ADDR_WIDTH:0]   R_LEVEL;
   logic                  R_UNDERFLOW;
   logic [ADDR_WIDTH:0]   R_PTR_GRAY;
   logic [ADDR_WIDTH-1:0] R_ADDR;

   modport slave (
      input  REN, UF_CLR, W_PTR_GRAY, R_DATA_Tx,
      output R_DATA, R_VALID, R_EMPTY, R_AEMPTY, R_LEVEL, R_UNDERFLOW, R_PTR_GRAY, R_ADDR
   );

   modport master (
      output REN, UF_CLR, W_PTR_GRAY, R_DATA_Tx,
      input  R_DATA, R_VALID, R_EMPTY, R_AEMPTY, R_LEVEL, R_UNDERFLOW, R_PTR_GRAY, R_ADDR
   );
endinterface

// File: rtl/afifo_rx_ctrl_v2.sv
// Read-domain controller of the async FIFO: Gray write-pointer sync, wrap-bit read pointer,
// registered or first-word-fall-through output, level / almost-empty / sticky underflow.
module afifo_rx_ctrl_v2 #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned SYNC_STAGE = 2,
   parameter int unsigned FWFT       = 0,
   parameter int unsigned AEMPTY_TH  = 2
) (
   input logic               CLK,
   input logic               RST,
   afifo_rx_ctrl_v2_if.slave bus
);
   localparam int unsigned   PW   = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AeTh = PW'(AEMPTY_TH);

   logic [PW-1:0]         sync_q [SYNC_STAGE];
   logic [PW-1:0]         w_gray_s, w_bin_s;
   logic [PW-1:0]         r_bin_q, r_bin_d, r_gray_q, r_gray_d;
   logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
   logic                  r_valid_q, r_valid_d, uf_q, uf_d;
   logic                  mem_empty, pop, r_empty;
   logic [PW-1:0]         mem_level, level;

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < SYNC_STAGE; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= bus.W_PTR_GRAY;
         for (int i = 1; i < SYNC_STAGE; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign w_gray_s = sync_q[SYNC_STAGE-1];

   // Gray to binary: each bit is the XOR of all Gray bits at or above it.
   always_comb begin
      w_bin_s = '0;
      for (int i = 0; i < PW; i++) w_bin_s[i] = ^(w_gray_s >> i);
   end

   always_comb begin
      mem_empty = (w_gray_s == r_gray_q);
      mem_level = w_bin_s - r_bin_q;
      if (FWFT != 0) begin
         // Load whenever the head register is free or being consumed this cycle.
         pop       = ~mem_empty & (~r_valid_q | bus.REN);
         r_valid_d = pop | (r_valid_q & ~bus.REN);
         r_empty   = ~r_valid_q;
         level     = mem_level + PW'(r_valid_q);
      end else begin
         pop       = bus.REN & ~mem_empty;
         r_valid_d = pop;
         r_empty   = mem_empty;
         level     = mem_level;
      end
      r_bin_d  = r_bin_q + PW'(pop);
      r_gray_d = r_bin_d ^ (r_bin_d >> 1);
      r_data_d = pop ? bus.R_DATA_Tx : r_data_q;
      // Set has priority over clear.
      uf_d     = (bus.REN & r_empty) | (uf_q & ~bus.UF_CLR);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_bin_q   <= '0;
         r_gray_q  <= '0;
         r_data_q  <= '0;
         r_valid_q <= 1'b0;
         uf_q      <= 1'b0;
      end else begin
         r_bin_q   <= r_bin_d;
         r_gray_q  <= r_gray_d;
         r_data_q  <= r_data_d;
         r_valid_q <= r_valid_d;
         uf_q      <= uf_d;
      end
   end

   assign bus.R_DATA      = r_data_q;
   assign bus.R_VALID     = r_valid_q;
   assign bus.R_EMPTY     = r_empty;
   assign bus.R_LEVEL     = level;
   assign bus.R_AEMPTY    = (level <= AeTh);
   assign bus.R_UNDERFLOW = uf_q;
   assign bus.R_PTR_GRAY  = r_gray_q;
   assign bus.R_ADDR      = r_bin_q[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_afifo_rx_ctrl_v2.sv
// Bench for afifo_rx_ctrl_v2: registered and FWFT instances checked against a queue-based
// model of FIFO contents, writer visibility delay and reader state.
module tb_afifo_rx_ctrl_v2;
   localparam int SYNC = 2;
   localparam int AETH = 2;

   logic clk = 1'b0;
   logic rst, ren, uf_clr;
   bit   mode;
   int   wcount;
   logic [31:0] mem [16];

   always #5 clk = ~clk;

   function automatic logic [4:0] g5(input int b);
      logic [4:0] v;
      v = 5'(b);
      return v ^ (v >> 1);
   endfunction

   afifo_rx_ctrl_v2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus0 ();
   afifo_rx_ctrl_v2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus1 ();

   assign bus0.REN        = ren;
   assign bus0.UF_CLR     = uf_clr;
   assign bus0.W_PTR_GRAY = g5(wcount);
   assign bus0.R_DATA_Tx  = mem[bus0.R_ADDR];
   assign bus1.REN        = ren;
   assign bus1.UF_CLR     = uf_clr;
   assign bus1.W_PTR_GRAY = g5(wcount);
   assign bus1.R_DATA_Tx  = mem[bus1.R_ADDR];

   afifo_rx_ctrl_v2 #(
      .DATA_WIDTH(32), .ADDR_WIDTH(4), .SYNC_STAGE(SYNC), .FWFT(0), .AEMPTY_TH(AETH)
   ) u_dut0 (
      .CLK (clk),
      .RST (rst),
      .bus (bus0)
   );

   afifo_rx_ctrl_v2 #(
      .DATA_WIDTH(32), .ADDR_WIDTH(4), .SYNC_STAGE(SYNC), .FWFT(1), .AEMPTY_TH(AETH)
   ) u_dut1 (
      .CLK (clk),
      .RST (rst),
      .bus (bus1)
   );

   logic [31:0] o_data;
   logic [4:0]  o_level, o_gray;
   logic [3:0]  o_addr;
   logic        o_valid, o_empty, o_aempty, o_uf;
   assign o_data   = mode ? bus1.R_DATA      : bus0.R_DATA;
   assign o_valid  = mode ? bus1.R_VALID     : bus0.R_VALID;
   assign o_empty  = mode ? bus1.R_EMPTY     : bus0.R_EMPTY;
   assign o_aempty = mode ? bus1.R_AEMPTY    : bus0.R_AEMPTY;
   assign o_level  = mode ? bus1.R_LEVEL     : bus0.R_LEVEL;
   assign o_uf     = mode ? bus1.R_UNDERFLOW : bus0.R_UNDERFLOW;
   assign o_gray   = mode ? bus1.R_PTR_GRAY  : bus0.R_PTR_GRAY;
   assign o_addr   = mode ? bus1.R_ADDR      : bus0.R_ADDR;

   // Model: words in write order, words read so far, writer counts seen by the reader.
   logic [31:0] exp_q [$];
   int          hist [$];
   int          rcnt;
   bit          hv;
   bit          uf_m;
   logic [31:0] hd;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_tests++;
      assert (obs === req) else begin
         n_fail++;
         $error("FAIL %s (mode %0d, t=%0t): observed %0h expected %0h", tag, mode, $time, obs, req);
      end
   endtask

   task automatic wr(input logic [31:0] d);
      mem[wcount % 16] = d;
      exp_q.push_back(d);
      wcount++;
   endtask

   task automatic step(input bit ren_v, input bit clr_v, input bit rst_v);
      int avail;
      int lvl;
      bit emp;
      ren    = ren_v;
      uf_clr = clr_v;
      rst    = rst_v;
      if (rst_v) begin
         rcnt = 0;
         hv   = 1'b0;
         hd   = '0;
         uf_m = 1'b0;
         exp_q = {};
         hist  = {};
         for (int i = 0; i < SYNC; i++) hist.push_back(0);
      end else begin
         avail = hist[0] - rcnt;
         emp   = mode ? !hv : (avail == 0);
         if (ren_v && emp) uf_m = 1'b1;
         else if (clr_v) uf_m = 1'b0;
         if (mode) begin
            if (avail > 0 && (!hv || ren_v)) begin
               hd = exp_q.pop_front();
               rcnt++;
               hv = 1'b1;
            end else if (ren_v && hv) begin
               hv = 1'b0;
            end
         end else begin
            hv = ren_v && (avail > 0);
            if (hv) begin
               hd = exp_q.pop_front();
               rcnt++;
            end
         end
         void'(hist.pop_front());
         hist.push_back(wcount);
      end
      @(posedge clk);
      #1;
      avail = hist[0] - rcnt;
      lvl   = avail + (mode ? int'(hv) : 0);
      chk("valid",  32'(o_valid),  32'(hv));
      chk("data",   o_data,        hd);
      chk("empty",  32'(o_empty),  mode ? 32'(!hv) : 32'(avail == 0));
      chk("level",  32'(o_level),  32'(lvl));
      chk("aempty", 32'(o_aempty), 32'(lvl <= AETH));
      chk("uflow",  32'(o_uf),     32'(uf_m));
      chk("ptr",    32'(o_gray),   32'(g5(rcnt)));
      chk("addr",   32'(o_addr),   32'(rcnt % 16));
   endtask

   task automatic do_reset(input int n);
      wcount = 0;
      repeat (n) step(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      mode   = 1'b0;
      ren    = 1'b0;
      uf_clr = 1'b0;
      rst    = 1'b1;
      wcount = 0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      for (int m = 0; m < 2; m++) begin
         mode = (m != 0);
         do_reset(2);
         // Three words, let them cross the synchroniser, then read them plus one underflow.
         wr(32'hAAAA_0001);
         wr(32'hBBBB_0002);
         wr(32'hCCCC_0003);
         repeat (3) step(1'b0, 1'b0, 1'b0);
         repeat (4) step(1'b1, 1'b0, 1'b0);
         step(1'b1, 1'b0, 1'b0);
         step(1'b1, 1'b1, 1'b0);
         step(1'b0, 1'b1, 1'b0);
         // Full FIFO must not look empty; then drain past empty.
         do_reset(1);
         for (int i = 0; i < 16; i++) wr($urandom);
         repeat (3) step(1'b0, 1'b0, 1'b0);
         repeat (19) step(1'b1, 1'b0, 1'b0);
         // Random traffic, wraps the pointers several times.
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 55 && (wcount - rcnt) < 16) wr($urandom);
            step($urandom_range(0, 99) < 50, $urandom_range(0, 7) == 0, 1'b0);
         end
         // Reset in the middle of a stream.
         if ((wcount - rcnt) < 16) wr($urandom);
         step(1'b1, 1'b0, 1'b0);
         do_reset(1);
         repeat (3) step(1'b0, 1'b0, 1'b0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
